// File: rtl/wu_stats_multi.sv
// Multi-channel wake-up statistics: classifies synchronised wake-up edges against
// trigger windows per channel and exposes coherent snapshots through one 32-bit readout.
module wu_stats_multi #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 20,
    parameter int LAT_W       = 32,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clki,
    input  logic              reset,
    input  logic              trig_in,
    input  logic [N_CH-1:0]   wake_up,
    input  logic [LAT_W-1:0]  win_len,
    input  logic              clear,
    input  logic              snap,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [31:0]       rd_data,
    output logic              snap_done
);

    typedef enum logic [1:0] {IDLE, ARMED, HIT} chState_e;

    logic [N_CH-1:0]  syncQ [SYNC_STAGES];
    logic [N_CH-1:0]  wakePrevQ;
    logic             trigPrevQ;
    logic [N_CH-1:0]  hit;
    logic             trigP;
    logic [LAT_W-1:0] winLast;

    chState_e         stateQ    [N_CH];
    chState_e         stateD    [N_CH];
    logic [LAT_W-1:0] latQ      [N_CH];
    logic [LAT_W-1:0] latD      [N_CH];
    logic [LAT_W-1:0] latInc    [N_CH];
    logic [N_CH-1:0]  closeWin;
    logic [CNT_W-1:0] tpQ       [N_CH];
    logic [CNT_W-1:0] tpD       [N_CH];
    logic [CNT_W-1:0] fpQ       [N_CH];
    logic [CNT_W-1:0] fpD       [N_CH];
    logic [CNT_W-1:0] missQ     [N_CH];
    logic [CNT_W-1:0] missD     [N_CH];
    logic [LAT_W-1:0] lastLatQ  [N_CH];
    logic [LAT_W-1:0] lastLatD  [N_CH];
    logic [LAT_W-1:0] maxLatQ   [N_CH];
    logic [LAT_W-1:0] maxLatD   [N_CH];
    logic [CNT_W-1:0] totalQ;
    logic [CNT_W-1:0] totalD;

    logic [CNT_W-1:0] shTpQ      [N_CH];
    logic [CNT_W-1:0] shFpQ      [N_CH];
    logic [CNT_W-1:0] shMissQ    [N_CH];
    logic [LAT_W-1:0] shLastLatQ [N_CH];
    logic [LAT_W-1:0] shMaxLatQ  [N_CH];
    logic [CNT_W-1:0] shTotalQ;

    logic [31:0]      rdDataQ;
    logic [31:0]      rdDataD;
    logic             snapDoneQ;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign hit     = syncQ[SYNC_STAGES-1] & ~wakePrevQ;
    assign trigP   = trig_in & ~trigPrevQ;
    // A zero window length behaves like a one-cycle window.
    assign winLast = (win_len == '0) ? '0 : win_len - LAT_W'(1);

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            latInc[i]   = (&latQ[i]) ? latQ[i] : latQ[i] + LAT_W'(1);
            closeWin[i] = (latQ[i] >= winLast) || (&latQ[i]);
        end
    end

    always_comb begin
        totalD = totalQ;
        if (clear) begin
            totalD = '0;
        end else if (trigP) begin
            totalD = satInc(totalQ);
        end
        for (int i = 0; i < N_CH; i++) begin
            stateD[i]   = stateQ[i];
            latD[i]     = latQ[i];
            tpD[i]      = tpQ[i];
            fpD[i]      = fpQ[i];
            missD[i]    = missQ[i];
            lastLatD[i] = lastLatQ[i];
            maxLatD[i]  = maxLatQ[i];
            if (clear) begin
                stateD[i]   = IDLE;
                latD[i]     = '0;
                tpD[i]      = '0;
                fpD[i]      = '0;
                missD[i]    = '0;
                lastLatD[i] = '0;
                maxLatD[i]  = '0;
            end else if (trigP) begin
                // A trigger always opens a fresh window; a coincident hit belongs to it.
                if (stateQ[i] == ARMED) begin
                    missD[i] = satInc(missQ[i]);
                end
                latD[i] = '0;
                if (hit[i]) begin
                    tpD[i]      = satInc(tpQ[i]);
                    lastLatD[i] = '0;
                    stateD[i]   = HIT;
                end else begin
                    stateD[i]   = ARMED;
                end
            end else begin
                case (stateQ[i])
                    IDLE: begin
                        if (hit[i]) begin
                            fpD[i] = satInc(fpQ[i]);
                        end
                    end
                    ARMED: begin
                        latD[i] = latInc[i];
                        if (hit[i]) begin
                            tpD[i]      = satInc(tpQ[i]);
                            lastLatD[i] = latQ[i];
                            maxLatD[i]  = (latQ[i] > maxLatQ[i]) ? latQ[i] : maxLatQ[i];
                            stateD[i]   = closeWin[i] ? IDLE : HIT;
                        end else if (closeWin[i]) begin
                            missD[i]  = satInc(missQ[i]);
                            stateD[i] = IDLE;
                        end
                    end
                    HIT: begin
                        latD[i] = latInc[i];
                        if (hit[i]) begin
                            fpD[i] = satInc(fpQ[i]);
                        end
                        if (closeWin[i]) begin
                            stateD[i] = IDLE;
                        end
                    end
                    default: begin
                        stateD[i] = IDLE;
                    end
                endcase
            end
        end
    end

    // Out-of-range channels and unused selectors read as zero.
    always_comb begin
        rdDataD = '0;
        if (int'(rd_ch) < N_CH) begin
            case (rd_sel)
                3'd0:    rdDataD = 32'(shTpQ[rd_ch]);
                3'd1:    rdDataD = 32'(shFpQ[rd_ch]);
                3'd2:    rdDataD = 32'(shMissQ[rd_ch]);
                3'd3:    rdDataD = 32'(shLastLatQ[rd_ch]);
                3'd4:    rdDataD = 32'(shMaxLatQ[rd_ch]);
                3'd5:    rdDataD = 32'(shTotalQ);
                default: rdDataD = '0;
            endcase
        end
    end

    always_ff @(posedge clki or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                syncQ[s] <= '0;
            end
            wakePrevQ <= '0;
            trigPrevQ <= 1'b0;
            totalQ    <= '0;
            shTotalQ  <= '0;
            rdDataQ   <= '0;
            snapDoneQ <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                stateQ[i]     <= IDLE;
                latQ[i]       <= '0;
                tpQ[i]        <= '0;
                fpQ[i]        <= '0;
                missQ[i]      <= '0;
                lastLatQ[i]   <= '0;
                maxLatQ[i]    <= '0;
                shTpQ[i]      <= '0;
                shFpQ[i]      <= '0;
                shMissQ[i]    <= '0;
                shLastLatQ[i] <= '0;
                shMaxLatQ[i]  <= '0;
            end
        end else begin
            syncQ[0] <= wake_up;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                syncQ[s] <= syncQ[s-1];
            end
            wakePrevQ <= syncQ[SYNC_STAGES-1];
            trigPrevQ <= trig_in;
            totalQ    <= totalD;
            rdDataQ   <= rdDataD;
            snapDoneQ <= snap;
            // Shadows take the registered live values, so same-cycle events and clears are excluded.
            if (snap) begin
                shTotalQ <= totalQ;
            end
            for (int i = 0; i < N_CH; i++) begin
                stateQ[i]   <= stateD[i];
                latQ[i]     <= latD[i];
                tpQ[i]      <= tpD[i];
                fpQ[i]      <= fpD[i];
                missQ[i]    <= missD[i];
                lastLatQ[i] <= lastLatD[i];
                maxLatQ[i]  <= maxLatD[i];
                if (snap) begin
                    shTpQ[i]      <= tpQ[i];
                    shFpQ[i]      <= fpQ[i];
                    shMissQ[i]    <= missQ[i];
                    shLastLatQ[i] <= lastLatQ[i];
                    shMaxLatQ[i]  <= maxLatQ[i];
                end
            end
        end
    end

    assign rd_data   = rdDataQ;
    assign snap_done = snapDoneQ;

endmodule

// File: tb/tb_wu_stats_multi.sv
// Directed self-checking bench for wu_stats_multi; inputs change and outputs are
// sampled on the falling clock edge, counters narrowed to 4 bits to reach saturation.
module tb_wu_stats_multi;

    logic        clki;
    logic        reset;
    logic        trig_in;
    logic [3:0]  wake_up;
    logic [31:0] win_len;
    logic        clear;
    logic        snap;
    logic [1:0]  rd_ch;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic        snap_done;

    int checks   = 0;
    int failures = 0;
    logic [31:0] val;

    wu_stats_multi #(
        .N_CH(4), .CNT_W(4), .LAT_W(32), .SYNC_STAGES(2)
    ) dut (
        .clki(clki), .reset(reset), .trig_in(trig_in), .wake_up(wake_up),
        .win_len(win_len), .clear(clear), .snap(snap), .rd_ch(rd_ch),
        .rd_sel(rd_sel), .rd_data(rd_data), .snap_done(snap_done)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    task automatic tick(input int n);
        repeat (n) @(negedge clki);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic readField(input int ch, input int sel, output logic [31:0] v);
        rd_ch  = 2'(ch);
        rd_sel = 3'(sel);
        tick(1);
        v = rd_data;
    endtask

    task automatic doSnap();
        snap = 1'b1;
        tick(1);
        snap = 1'b0;
        checkOutput("snap_done", {31'd0, snap_done}, 32'd1);
        tick(1);
    endtask

    task automatic doClear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic trigPulse();
        trig_in = 1'b1;
        tick(1);
        trig_in = 1'b0;
    endtask

    // Hit reaches the FSM two edges after the wake edge, so latency L needs the wake L-1 cycles after the trigger.
    task automatic trigThenWake(input int ch, input int lat);
        trigPulse();
        tick(lat - 2);
        wake_up[ch] = 1'b1;
        tick(3);
        wake_up[ch] = 1'b0;
        tick(2);
    endtask

    initial begin
        reset = 1'b1; trig_in = 1'b0; wake_up = '0; win_len = 32'd100;
        clear = 1'b0; snap = 1'b0; rd_ch = '0; rd_sel = '0;
        tick(3);
        checkOutput("reset_rd_data", rd_data, 32'd0);
        checkOutput("reset_snap_done", {31'd0, snap_done}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Basic true positive at latency 37
        win_len = 32'd100;
        trigThenWake(0, 37);
        tick(70);
        doSnap();
        readField(0, 0, val); checkOutput("t1_tp", val, 32'd1);
        readField(0, 3, val); checkOutput("t1_last_lat", val, 32'd37);
        readField(0, 4, val); checkOutput("t1_max_lat", val, 32'd37);
        readField(0, 5, val); checkOutput("t1_total", val, 32'd1);
        readField(0, 1, val); checkOutput("t1_fp", val, 32'd0);
        readField(0, 2, val); checkOutput("t1_missed", val, 32'd0);
        readField(1, 2, val); checkOutput("t1_ch1_missed", val, 32'd1);
        readField(0, 6, val); checkOutput("t1_sel6_zero", val, 32'd0);

        // Missed window, stray wake and a second hit inside a window
        doClear();
        win_len = 32'd50;
        trigPulse();
        tick(60);
        doSnap();
        readField(0, 2, val); checkOutput("t2_ch0_missed", val, 32'd1);
        wake_up[1] = 1'b1; tick(4); wake_up[1] = 1'b0; tick(2);
        trigThenWake(2, 10);
        tick(5);
        wake_up[2] = 1'b1; tick(3); wake_up[2] = 1'b0;
        tick(40);
        doSnap();
        readField(1, 1, val); checkOutput("t2_ch1_fp", val, 32'd1);
        readField(2, 0, val); checkOutput("t2_ch2_tp", val, 32'd1);
        readField(2, 1, val); checkOutput("t2_ch2_fp", val, 32'd1);
        readField(2, 3, val); checkOutput("t2_ch2_last_lat", val, 32'd10);
        readField(0, 2, val); checkOutput("t2_ch0_missed_total", val, 32'd2);

        // Re-trigger at t=30 with the hit coinciding with the second trigger pulse
        doClear();
        win_len = 32'd100;
        trigPulse();
        tick(28);
        wake_up[0] = 1'b1;
        tick(1);
        trigPulse();
        tick(2);
        wake_up[0] = 1'b0;
        tick(110);
        doSnap();
        readField(0, 2, val); checkOutput("t3_missed", val, 32'd1);
        readField(0, 0, val); checkOutput("t3_tp", val, 32'd1);
        readField(0, 3, val); checkOutput("t3_last_lat", val, 32'd0);
        readField(0, 5, val); checkOutput("t3_total", val, 32'd2);

        // Saturation of the 4-bit FP counter
        doClear();
        for (int k = 0; k < 20; k++) begin
            wake_up[3] = 1'b1; tick(3);
            wake_up[3] = 1'b0; tick(3);
        end
        doSnap();
        readField(3, 1, val); checkOutput("t4_fp_sat", val, 32'd15);

        // Snap and clear in the same cycle
        doClear();
        win_len = 32'd8;
        for (int k = 0; k < 5; k++) begin
            trigThenWake(0, 3);
            tick(5);
        end
        rd_ch = 2'd0; rd_sel = 3'd0;
        snap = 1'b1; clear = 1'b1;
        tick(1);
        snap = 1'b0; clear = 1'b0;
        checkOutput("t5_snap_done", {31'd0, snap_done}, 32'd1);
        tick(1);
        checkOutput("t5_tp_pre_clear", rd_data, 32'd5);
        checkOutput("t5_snap_done_low", {31'd0, snap_done}, 32'd0);
        doSnap();
        readField(0, 0, val); checkOutput("t5_tp_after_clear", val, 32'd0);

        // Asynchronous reset in the middle of an armed window
        win_len = 32'd100;
        trigPulse();
        tick(3);
        doSnap();
        readField(0, 5, val); checkOutput("t6_total_pre_reset", val, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("t6_rd_data_in_reset", rd_data, 32'd0);
        tick(2);
        checkOutput("t6_rd_data_held", rd_data, 32'd0);
        reset = 1'b0;
        tick(2);
        win_len = 32'd20;
        trigThenWake(0, 5);
        tick(30);
        doSnap();
        readField(0, 2, val); checkOutput("t6_missed", val, 32'd0);
        readField(0, 0, val); checkOutput("t6_tp", val, 32'd1);
        readField(0, 3, val); checkOutput("t6_last_lat", val, 32'd5);
        readField(0, 5, val); checkOutput("t6_total", val, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
